// File: rtl/imem_arbiter_pkg.sv
// Shared encodings and constants for the instruction/data memory arbiter.
package imem_arbiter_pkg;

    // Word-address width of the program/data memory.
    localparam int InstMemNumLog2 = 17;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;

    // Fetches always read the full word.
    localparam logic [3:0]  SelAll      = 4'hF;
    localparam logic [3:0]  SelNone     = 4'h0;

    // Arbiter sequencing: IDLE samples requests, ISSUE drives the memory,
    // RESP returns data (and may grant the next request back-to-back).
    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbIssue = 2'd1,
        ArbResp  = 2'd2
    } arb_state_e;

    // Owner of the transaction currently in flight.
    typedef enum logic {
        GntIf = 1'b0,
        GntDm = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/imem_arbiter.sv
// Serializes IF fetches and MEM loads/stores onto one single-port synchronous
// memory. The data port has fixed priority; each access takes ISSUE + RESP.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W = InstMemNumLog2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    // Instruction fetch port
    input  logic              if_ce,
    input  logic [31:0]       if_addr,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_ready,
    output logic              stallreq_if,

    // Load/store port
    input  logic              dm_ce,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [3:0]        dm_sel,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stallreq_mem,

    // Memory macro side
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q,     state_d;
    arb_gnt_e          gnt_q,       gnt_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_we_q,    mem_we_d;
    logic [3:0]        mem_sel_q,   mem_sel_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic resp_if;
    logic resp_dm;
    logic req_if;
    logic req_dm;

    // The port being answered this cycle cannot be re-granted until its
    // requester has had a chance to drop or change its request.
    assign resp_if = (state_q == ArbResp) && (gnt_q == GntIf);
    assign resp_dm = (state_q == ArbResp) && (gnt_q == GntDm);
    assign req_dm  = dm_ce && !resp_dm;
    assign req_if  = if_ce && !resp_if;

    // Next-state and next-request-register logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ArbIssue: begin
                state_d = ArbResp;
            end

            ArbIdle, ArbResp: begin
                if (req_dm) begin
                    state_d     = ArbIssue;
                    gnt_d       = GntDm;
                    mem_addr_d  = dm_addr[ADDR_W+1:2];
                    mem_we_d    = dm_we;
                    mem_sel_d   = dm_sel;
                    mem_wdata_d = dm_wdata;
                end else if (req_if) begin
                    state_d     = ArbIssue;
                    gnt_d       = GntIf;
                    mem_addr_d  = if_addr[ADDR_W+1:2];
                    mem_we_d    = 1'b0;
                    mem_sel_d   = SelAll;
                    mem_wdata_d = '0;
                end else begin
                    state_d     = ArbIdle;
                    mem_we_d    = 1'b0;
                    mem_sel_d   = SelNone;
                    mem_wdata_d = '0;
                end
            end

            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    // State and registered memory-request outputs, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst == RstEnable) begin
            state_q     <= ArbIdle;
            gnt_q       <= GntIf;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= SelNone;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Reset in ISSUE must abort the access, so the enable is gated directly.
    assign mem_ce    = (state_q == ArbIssue) && (rst != RstEnable);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_sel   = mem_sel_q;
    assign mem_wdata = mem_wdata_q;

    // Ready is not gated by reset: a RESP cycle under reset still completes.
    assign if_ready  = resp_if;
    assign dm_ready  = resp_dm;
    assign if_inst   = resp_if ? mem_rdata : '0;
    // mem_we_q still describes the finishing access during RESP.
    assign dm_rdata  = (resp_dm && !mem_we_q) ? mem_rdata : '0;

    assign stallreq_if  = if_ce && !if_ready;
    assign stallreq_mem = dm_ce && !dm_ready;

    // Byte offset and out-of-range address bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                dm_addr[31:ADDR_W+2], dm_addr[1:0]};

endmodule
